sipo_deserializer: RTL and testbench
====================================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports clk and rst named as in the codebase.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst  input  1  Asynchronous, active-low reset.
REQ-004 serial_in  input  1  Serial data bit, MSB first; it is the upstream serializer's serial_out.
REQ-005 serial_valid  input  1  Bit strobe; serial_in is sampled only on edges where this is high.
REQ-006 frame_abort  input  1  Synchronous discard of the partial frame.
REQ-007 parallel_out  output  8  Assembled word; held stable while out_valid=1.
REQ-008 out_valid  output  1  Word available to the consumer.
REQ-009 out_ready  input  1  Consumer accepts; transfer occurs when out_valid and out_ready are both high.
REQ-010 overrun  output  1  Sticky flag; a completed word was dropped.
REQ-011 overrun_clr  input  1  Synchronous clear of overrun.
REQ-012 busy  output  1  High while a frame is partially received (state not IDLE).
REQ-013 parity_err  output  1  Parity mismatch for the word currently held; see Configuration.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT and PARITY; PARITY exists only when PARITY_CHECK_EN is defined.
REQ-015 IDLE->SHIFT SHALL occur on the first accepted bit, with bit_cnt set to 1.
REQ-016 SHIFT SHALL load shift_reg <= {shift_reg[6:0], serial_in} and increment the 4-bit bit_cnt on each accepted bit.
REQ-017 On the 8th accepted bit the word {shift_reg[6:0], serial_in} SHALL complete, and the FSM SHALL go to IDLE without the macro, or to PARITY with it.
REQ-018 Completion latency SHALL be: out_valid rises on the edge that accepts the last frame bit, so the word is visible in the following cycle.
REQ-019 Idle cycles where serial_valid=0 SHALL hold all state; gaps between bits are unlimited.
REQ-020 Output hold, case 1: on completion with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle, the block SHALL load parallel_out and keep or set out_valid=1.
REQ-021 Output hold, case 2: on completion with out_valid=1 and out_ready=0, the block SHALL drop the new word, keep parallel_out unchanged, and set overrun=1.
REQ-022 A handshake with no completion in the same cycle SHALL clear out_valid.
REQ-023 frame_abort SHALL force IDLE and clear bit_cnt and shift_reg, and SHALL produce no output word.
REQ-024 frame_abort SHALL take priority over serial_valid in the same cycle.
REQ-025 frame_abort SHALL NOT affect out_valid, parallel_out or overrun.
REQ-026 overrun_clr SHALL clear overrun, except that an overrun event in the same cycle wins and sets it.
REQ-027 Back-to-back frames with no idle cycle SHALL be supported; the bit after the completing bit starts a new frame.

Reset
REQ-028 Asserting rst=0 SHALL immediately set: state=IDLE, shift_reg=0, bit_cnt=0, parallel_out=0x00, out_valid=0, overrun=0, busy=0, parity_err=0.
REQ-029 Reset mid-frame SHALL discard the partial frame, and the first accepted bit after release SHALL be bit 7 of a new word.

Configuration
REQ-030 Macro PARITY_CHECK_EN, when defined, SHALL make a frame 9 bits: 8 data bits followed by 1 even-parity bit.
REQ-031 With PARITY_CHECK_EN defined, the word SHALL complete on the parity bit, and parity_err SHALL be loaded with the output word as (^data) ^ parity_bit.
REQ-032 With PARITY_CHECK_EN defined, a word with a parity mismatch SHALL still be delivered.
REQ-033 With PARITY_CHECK_EN undefined, the frame SHALL be 8 bits, the PARITY state SHALL be absent, and parity_err SHALL be tied to 0.

Structure
REQ-034 Package sipo_pkg SHALL hold: DATA_W=8; CNT_W=4; the FSM state enum; and FRAME_BITS, derived as 8 without the macro or 9 with it.
REQ-035 One sub-module, sipo_out_reg, SHALL contain the output holding register, the valid/ready logic and the overrun logic.
REQ-036 Target size SHALL be about 150-250 lines of RTL in total.

Verification
REQ-037 Scenario: bits 1,0,1,0,0,1,0,1 on consecutive strobes with out_ready=1 -> parallel_out=0xA5 and out_valid=1 one cycle after the 8th bit; overrun=0.
REQ-038 Scenario: 0x3C sent with random serial_valid gaps of 0-5 cycles -> parallel_out=0x3C; busy=1 from the 1st bit until completion.
REQ-039 Scenario: out_ready=0, send 0x11 then 0x22 -> parallel_out stays 0x11 and overrun=1; then out_ready=1 for one cycle -> out_valid=0; then overrun_clr -> overrun=0.
REQ-040 Scenario: 4 bits of 0xF0, then frame_abort, then full 0x0F -> exactly one word is delivered, equal to 0x0F.
REQ-041 Scenario: rst=0 after 5 bits, release, then send 0x81 -> all outputs are 0 during reset, and the only word delivered is 0x81.
REQ-042 Scenario (PARITY_CHECK_EN defined): 0x07 with parity bit 1 -> parity_err=0; 0x07 with parity bit 0 -> parity_err=1, and the word 0x07 is still delivered.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and sizing for the serial-to-parallel deserializer.
// Optional feature macro: PARITY_CHECK_EN (adds an even-parity bit per frame).
package sipo_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

`ifdef PARITY_CHECK_EN
    localparam int FRAME_BITS = DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    localparam int FRAME_BITS = DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/sipo_deserializer_out_reg.sv
// Output holding register for the deserializer: keeps the delivered word
// stable until the consumer takes it, and flags words lost to a full holder.
module sipo_out_reg
    import sipo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              word_done,
    input  logic [DATA_W-1:0] word_in,
    input  logic              word_perr,
    input  logic              out_ready,
    input  logic              overrun_clr,
    output logic [DATA_W-1:0] parallel_out,
    output logic              out_valid,
    output logic              overrun,
    output logic              parity_err
);

    logic load_word;
    logic drop_word;

    // A finished word goes in if the holder is empty or emptying this cycle;
    // otherwise it is lost and the overrun flag records that.
    always_comb begin
        load_word = word_done && (!out_valid || out_ready);
        drop_word = word_done && out_valid && !out_ready;
    end

    // Holding register and valid flag; a handshake without a new word empties it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parallel_out <= '0;
            parity_err   <= 1'b0;
            out_valid    <= 1'b0;
        end else if (load_word) begin
            parallel_out <= word_in;
            parity_err   <= word_perr;
            out_valid    <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (drop_word) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer, MSB first, with a valid/ready output holder.
// Optional feature macro: PARITY_CHECK_EN (9-bit frames, even parity checked).
module sipo_deserializer
    import sipo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              serial_valid,
    input  logic              frame_abort,
    output logic [DATA_W-1:0] parallel_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic              busy,
    output logic              parity_err
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              word_done;
    logic [DATA_W-1:0] word;
    logic              word_perr;

    // Frame state, shift register and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= cnt_next;
        end
    end

    // Next-state logic: abort wins over a bit strobe, and the completing bit
    // returns to IDLE so the very next strobe begins a fresh frame.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        word_done  = 1'b0;
        word_perr  = 1'b0;
`ifdef PARITY_CHECK_EN
        word       = shift_reg;
`else
        word       = {shift_reg[DATA_W-2:0], serial_in};
`endif
        if (frame_abort) begin
            state_next = IDLE;
            shift_next = '0;
            cnt_next   = '0;
        end else if (serial_valid) begin
            case (state)
                IDLE: begin
                    shift_next = {shift_reg[DATA_W-2:0], serial_in};
                    cnt_next   = CNT_W'(1);
                    state_next = SHIFT;
                end
                SHIFT: begin
                    shift_next = {shift_reg[DATA_W-2:0], serial_in};
                    cnt_next   = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_next = PARITY;
`else
                        word_done  = 1'b1;
                        state_next = IDLE;
                        shift_next = '0;
                        cnt_next   = '0;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    word_perr  = (^shift_reg) ^ serial_in;
                    word_done  = 1'b1;
                    state_next = IDLE;
                    shift_next = '0;
                    cnt_next   = '0;
                end
`endif
                default: begin
                    state_next = IDLE;
                    shift_next = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // A partially received frame is anything other than IDLE.
    always_comb begin
        busy = (state != IDLE);
    end

    sipo_out_reg u_out_reg (
        .clk          (clk),
        .rst          (rst),
        .word_done    (word_done),
        .word_in      (word),
        .word_perr    (word_perr),
        .out_ready    (out_ready),
        .overrun_clr  (overrun_clr),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .overrun      (overrun),
        .parity_err   (parity_err)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed frames, scoreboard of
// expected delivered words, and direct checks of flags around each scenario.
// Covers the optional PARITY_CHECK_EN build when that macro is defined.
module tb_sipo_deserializer;
    import sipo_pkg::*;

    logic              clk;
    logic              rst;
    logic              serial_in;
    logic              serial_valid;
    logic              frame_abort;
    logic [DATA_W-1:0] parallel_out;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;
    logic              overrun_clr;
    logic              busy;
    logic              parity_err;

    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic              perr;
    } sb_t;

    sb_t sb[$];
    int  checks    = 0;
    int  failures  = 0;
    int  delivered = 0;

    sipo_deserializer dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame_abort  (frame_abort),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .busy         (busy),
        .parity_err   (parity_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b);
        serial_in    = b;
        serial_valid = 1'b1;
        tick();
        serial_valid = 1'b0;
    endtask

    // Send one frame MSB first with random 0..max_gap idle cycles between bits.
    // When busy_chk is set, busy is checked after every bit of the frame.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic par,
                                 input int max_gap, input bit deliver, input bit busy_chk);
        logic [FRAME_BITS-1:0] frame;
        int                    gap;
`ifdef PARITY_CHECK_EN
        frame = {data, par};
`else
        frame = data;
        if (par) begin
            frame = data;
        end
`endif
        if (deliver) begin
`ifdef PARITY_CHECK_EN
            sb.push_back('{word: data, perr: (^data) ^ par});
`else
            sb.push_back('{word: data, perr: 1'b0});
`endif
        end
        for (int i = FRAME_BITS - 1; i >= 0; i--) begin
            sendBit(frame[i]);
            if (busy_chk) begin
                @(negedge clk);
                checkOutput("busy_during_frame", 8'(busy), 8'(i != 0));
            end
            gap = (i != 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gap) tick();
        end
    endtask

    // Wait, with a bound, for every expected word to be consumed.
    task automatic waitDrain(input string tag);
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
        tick();
        checkOutput(tag, 8'(sb.size()), 8'd0);
    endtask

    // Scoreboard consumer: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            sb_t exp_item;
            delivered++;
            checks++;
            assert (sb.size() != 0)
            else begin
                failures++;
                $error("[TB] FAIL unexpected_word observed=0x%h expected=none", parallel_out);
            end
            if (sb.size() != 0) begin
                exp_item = sb.pop_front();
                checkOutput("sb_word", parallel_out, exp_item.word);
                checkOutput("sb_parity_err", 8'(parity_err), 8'(exp_item.perr));
            end
        end
    end

    initial begin
        int d0;
        rst          = 1'b0;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        frame_abort  = 1'b0;
        out_ready    = 1'b1;
        overrun_clr  = 1'b0;

        // Reset state.
        #3;
        checkOutput("rst_parallel_out", parallel_out, 8'h00);
        checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
        checkOutput("rst_overrun", 8'(overrun), 8'd0);
        checkOutput("rst_busy", 8'(busy), 8'd0);
        checkOutput("rst_parity_err", 8'(parity_err), 8'd0);
        tick();
        rst = 1'b1;
        tick();

        // 0xA5 on consecutive strobes; valid appears the cycle after the last bit.
        $display("[TB] scenario: 0xA5 back-to-back bits");
        sb.push_back('{word: 8'hA5, perr: 1'b0});
        begin
            logic [FRAME_BITS-1:0] f;
`ifdef PARITY_CHECK_EN
            f = {8'hA5, 1'b0};
`else
            f = 8'hA5;
`endif
            for (int i = FRAME_BITS - 1; i >= 1; i--) sendBit(f[i]);
            @(negedge clk);
            checkOutput("a5_not_valid_early", 8'(out_valid), 8'd0);
            sendBit(f[0]);
        end
        @(negedge clk);
        checkOutput("a5_out_valid", 8'(out_valid), 8'd1);
        checkOutput("a5_parallel_out", parallel_out, 8'hA5);
        checkOutput("a5_overrun", 8'(overrun), 8'd0);
        checkOutput("a5_busy_after", 8'(busy), 8'd0);
        waitDrain("a5_drain");

        // Back-to-back frames without idle cycles.
        $display("[TB] scenario: back-to-back frames");
        applyStimulus(8'h5A, 1'b0, 0, 1'b1, 1'b0);
        applyStimulus(8'hC3, 1'b0, 0, 1'b1, 1'b0);
        waitDrain("b2b_drain");

        // 0x3C with random gaps; busy held through the frame.
        $display("[TB] scenario: 0x3C with gaps");
        checkOutput("gap_busy_before", 8'(busy), 8'd0);
        applyStimulus(8'h3C, 1'b0, 5, 1'b1, 1'b1);
        checkOutput("gap_parallel_out", parallel_out, 8'h3C);
        waitDrain("gap_drain");

        // Consumer stalled: second word is dropped and overrun raised.
        $display("[TB] scenario: overrun");
        out_ready = 1'b0;
        applyStimulus(8'h11, 1'b0, 0, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ovr_parallel_out", parallel_out, 8'h11);
        checkOutput("ovr_out_valid", 8'(out_valid), 8'd1);
        checkOutput("ovr_overrun", 8'(overrun), 8'd1);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("ovr_valid_cleared", 8'(out_valid), 8'd0);
        checkOutput("ovr_still_sticky", 8'(overrun), 8'd1);
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        @(negedge clk);
        checkOutput("ovr_cleared", 8'(overrun), 8'd0);
        out_ready = 1'b1;
        tick();

        // Partial frame aborted (abort together with a strobe), then 0x0F.
        $display("[TB] scenario: frame abort");
        d0 = delivered;
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        @(negedge clk);
        checkOutput("abort_busy_before", 8'(busy), 8'd1);
        tick();
        frame_abort  = 1'b1;
        serial_valid = 1'b1;
        serial_in    = 1'b1;
        tick();
        frame_abort  = 1'b0;
        serial_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy_after", 8'(busy), 8'd0);
        checkOutput("abort_no_valid", 8'(out_valid), 8'd0);
        applyStimulus(8'h0F, 1'b0, 2, 1'b1, 1'b0);
        waitDrain("abort_drain");
        checkOutput("abort_one_word", 8'(delivered - d0), 8'd1);

        // Asynchronous reset mid-frame, then 0x81.
        $display("[TB] scenario: reset mid-frame");
        d0 = delivered;
        for (int i = 0; i < 5; i++) sendBit(i[0]);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mrst_parallel_out", parallel_out, 8'h00);
        checkOutput("mrst_out_valid", 8'(out_valid), 8'd0);
        checkOutput("mrst_overrun", 8'(overrun), 8'd0);
        checkOutput("mrst_busy", 8'(busy), 8'd0);
        checkOutput("mrst_parity_err", 8'(parity_err), 8'd0);
        tick();
        rst = 1'b1;
        tick();
        applyStimulus(8'h81, 1'b0, 1, 1'b1, 1'b0);
        waitDrain("mrst_drain");
        checkOutput("mrst_one_word", 8'(delivered - d0), 8'd1);

`ifdef PARITY_CHECK_EN
        // Even parity: 0x07 has odd weight, so a parity bit of 1 is correct.
        $display("[TB] scenario: parity");
        applyStimulus(8'h07, 1'b1, 0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("par_ok_err", 8'(parity_err), 8'd0);
        waitDrain("par_ok_drain");
        applyStimulus(8'h07, 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("par_bad_err", 8'(parity_err), 8'd1);
        checkOutput("par_bad_word", parallel_out, 8'h07);
        waitDrain("par_bad_drain");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
